ad_ip_jesd204_tpl_adc_pack: RTL and testbench
=============================================

// Module: ad_ip_jesd204_tpl_adc_pack
// PURPOSE
//  Channel packer directly downstream of the JESD204 ADC transport layer, upstream of the ADC DMA write FIFO.
//  Takes the per-channel sample bus (all channels present every valid beat) plus the channel enable mask.
//  Compacts the samples of enabled channels only into full-width DMA words; disabled channels consume no DMA bandwidth.
//  Returns DMA overflow to the transport layer's adc_dovf input.
// PARAMETERS
//  NUM_CHANNELS         4   converter channels on the input bus (1..16)
//  SAMPLES_PER_CHANNEL  1   samples per channel per beat (transport DATA_PATH_WIDTH)
//  SAMPLE_DATA_WIDTH    16  bits per sample (transport BITS_PER_SAMPLE)
// PORTS
//  clk                clock  1         link clock (same domain as transport layer)
//  reset              in     1         synchronous, active-high reset
//  enable             in     NUM_CHANNELS  channel enable mask, quasi-static
//  fifo_wr_en         in     1         input beat valid (OR of adc_valid)
//  fifo_wr_data       in     NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH (D)  channel c at [c*S*W +: S*W], sample s at +s*W
//  fifo_wr_overflow   out    1         registered copy of packed_fifo_wr_overflow, feeds adc_dovf
//  packed_fifo_wr_en  out    1         packed word valid
//  packed_fifo_wr_data out   D         packed word, slot 0 at LSB
//  packed_fifo_wr_sync out   1         first packed word after reset or enable change
//  packed_fifo_wr_overflow in 1        DMA FIFO overflow
// BEHAVIOUR
//  Terms: E = popcount(enable); slot = one W-bit sample; word = N*S slots (N=NUM_CHANNELS, S=SAMPLES_PER_CHANNEL).
//  Reset values: all outputs 0, buffer level 0, sync_pending 1.
//  Input order per beat is sample-major: s=0..S-1, and within each s the enabled channels ascending.
//    These E*S slots are appended to the buffer at the current level.
//  Buffer: 2*N*S slots; level counter is clog2(2*N*S)+1 bits.
//    Next level = level + E*S, minus N*S if an emit occurs.
//  Emit: when level + E*S >= N*S on an accepted beat:
//    - next cycle packed_fifo_wr_en=1 and packed_fifo_wr_data = slots 0..N*S-1;
//    - the remaining slots shift down to slot 0.
//    - Latency is exactly one clk from the completing fifo_wr_en beat.
//    - At most one word per beat (E*S <= N*S guarantees no backlog).
//  packed_fifo_wr_en pulses for one cycle per emitted word; packed_fifo_wr_data holds its value when en=0.
//  No backpressure: the DMA FIFO is never stalled; loss is reported only through overflow.
//  E = 0: input beats are ignored, level stays 0, no output.
//  E = N (all channels enabled): one word per beat, pass-through with one cycle of latency, level stays 0.
//  Enable change: detected by comparing against a registered enable.
//    - In the cycle after the change: level := 0 (partial word discarded), sync_pending := 1.
//    - A beat coincident with the change cycle is packed using the new mask into an empty buffer.
//  packed_fifo_wr_sync equals sync_pending on an emitted word; sync_pending clears when that word is emitted.
//  fifo_wr_overflow = packed_fifo_wr_overflow delayed one clk; reset clears it.
//  Reset mid-operation: partial data discarded, any in-flight emit suppressed, state as after reset.
//  Fully synchronous single clock; no combinational path from input to output.
// TESTING
//  1. N=4,S=1,W=16, enable=4'hF, beats {D3,C2,B1,A0}
//     -> identical word one clk later, sync=1 on first word only.
//  2. enable=4'b0101, beats (A0,C0),(A1,C1)
//     -> single word {C1,A1,C0,A0} one clk after 2nd beat; no output after 1st.
//  3. enable=4'b0111, 4 beats (12 slots)
//     -> words after beats 2,3,4; word0={A1,C0,B0,A0}, word2={C3,B3,A3,C2}; level returns 0.
//  4. enable 4'b0101 -> 4'b0001 after one beat
//     -> partial (A0,C0) dropped; next word {A4,A3,A2,A1} after 4 more beats with sync=1.
//  5. reset asserted one cycle while level=2 -> no emit; all outputs 0; next word carries sync=1.
//  6. packed_fifo_wr_overflow pulse 3 cycles -> fifo_wr_overflow high 3 cycles, one clk later.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_pack_if.sv
// Bus between the ADC transport layer, the channel packer and the DMA write FIFO.
// The packer connects through the slave modport; the driving environment uses master.
interface ad_ip_jesd204_tpl_adc_pack_if #(
   parameter int NUM_CHANNELS        = 4,
   parameter int SAMPLES_PER_CHANNEL = 1,
   parameter int SAMPLE_DATA_WIDTH   = 16
);
   localparam int DW = NUM_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;

   logic [NUM_CHANNELS-1:0] enable;
   logic                    fifo_wr_en;
   logic [DW-1:0]           fifo_wr_data;
   logic                    fifo_wr_overflow;
   logic                    packed_fifo_wr_en;
   logic [DW-1:0]           packed_fifo_wr_data;
   logic                    packed_fifo_wr_sync;
   logic                    packed_fifo_wr_overflow;

   modport slave (
      input  enable, fifo_wr_en, fifo_wr_data, packed_fifo_wr_overflow,
      output fifo_wr_overflow, packed_fifo_wr_en, packed_fifo_wr_data, packed_fifo_wr_sync
   );

   modport master (
      output enable, fifo_wr_en, fifo_wr_data, packed_fifo_wr_overflow,
      input  fifo_wr_overflow, packed_fifo_wr_en, packed_fifo_wr_data, packed_fifo_wr_sync
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Compacts the samples of enabled ADC channels into full-width DMA words,
// one cycle after the beat that completes a word.
module ad_ip_jesd204_tpl_adc_pack #(
   parameter int NUM_CHANNELS        = 4,
   parameter int SAMPLES_PER_CHANNEL = 1,
   parameter int SAMPLE_DATA_WIDTH   = 16
) (
   input logic                      clk,
   input logic                      reset,
   ad_ip_jesd204_tpl_adc_pack_if.slave bus
);
   localparam int N  = NUM_CHANNELS;
   localparam int S  = SAMPLES_PER_CHANNEL;
   localparam int W  = SAMPLE_DATA_WIDTH;
   localparam int NS = N * S;
   localparam int DW = NS * W;
   localparam int LW = $clog2(2 * NS) + 1;

   logic [N-1:0]    enable_q;
   logic [2*DW-1:0] slots;
   logic [LW-1:0]   level;
   logic            sync_pending;

   logic            changed;
   logic [LW-1:0]   level_eff;
   logic            sync_eff;
   logic [DW-1:0]   comp;
   logic [2*DW-1:0] merged;
   logic [LW-1:0]   total;
   logic            emit;

   // NOTE: blocking assignments are correct here; the loop index k must update within one evaluation.
   always_comb begin
      int k;
      changed   = (bus.enable != enable_q);
      level_eff = changed ? '0 : level;
      sync_eff  = changed | sync_pending;

      // Sample-major order: for each sample index, enabled channels ascending.
      comp = '0;
      k    = 0;
      for (int s = 0; s < S; s++) begin
         for (int c = 0; c < N; c++) begin
            if (bus.enable[c]) begin
               comp[k*W +: W] = bus.fifo_wr_data[(c*S + s)*W +: W];
               k++;
            end
         end
      end

      merged = '0;
      for (int i = 0; i < 2*NS; i++) begin
         if (i < int'(level_eff))
            merged[i*W +: W] = slots[i*W +: W];
         else if ((i - int'(level_eff)) < k)
            merged[i*W +: W] = comp[(i - int'(level_eff))*W +: W];
      end

      total = level_eff + LW'(k);
      emit  = bus.fifo_wr_en && (total >= LW'(NS));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q                <= '0;
         level                   <= '0;
         sync_pending            <= 1'b1;
         bus.packed_fifo_wr_en   <= 1'b0;
         bus.packed_fifo_wr_data <= '0;
         bus.packed_fifo_wr_sync <= 1'b0;
         bus.fifo_wr_overflow    <= 1'b0;
      end else begin
         enable_q                <= bus.enable;
         bus.fifo_wr_overflow    <= bus.packed_fifo_wr_overflow;
         bus.packed_fifo_wr_en   <= emit;
         bus.packed_fifo_wr_sync <= emit & sync_eff;
         if (emit) begin
            bus.packed_fifo_wr_data <= merged[DW-1:0];
            level                   <= total - LW'(NS);
            sync_pending            <= 1'b0;
         end else if (bus.fifo_wr_en) begin
            level        <= total;
            sync_pending <= sync_eff;
         end else begin
            level        <= level_eff;
            sync_pending <= sync_eff;
         end
      end
   end

   // NOTE: sample storage has no reset; level alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (emit)
         slots <= {{DW{1'b0}}, merged[2*DW-1:DW]};
      else if (bus.fifo_wr_en)
         slots <= merged;
   end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Directed table-driven bench for the ADC channel packer (N=4, S=1, W=16),
// plus a hand-written overflow delay sequence.
module tb_ad_ip_jesd204_tpl_adc_pack;
   localparam int N  = 4;
   localparam int S  = 1;
   localparam int W  = 16;
   localparam int DW = N * S * W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ad_ip_jesd204_tpl_adc_pack_if #(.NUM_CHANNELS(N), .SAMPLES_PER_CHANNEL(S), .SAMPLE_DATA_WIDTH(W)) bus ();

   ad_ip_jesd204_tpl_adc_pack #(.NUM_CHANNELS(N), .SAMPLES_PER_CHANNEL(S), .SAMPLE_DATA_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic          rst;
      logic [N-1:0]  en;
      logic          we;
      logic [DW-1:0] data;
      logic          exp_en;
      logic [DW-1:0] exp_data;
      logic          exp_sync;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] hold;
   int            n_vec;
   int            n_fail;

   // Sample n of channel ch (A..D) is 0xA0nn, 0xB0nn, 0xC0nn, 0xD0nn.
   function automatic logic [W-1:0] smp(int ch, int n);
      return {4'(10 + ch), 4'h0, 8'(n)};
   endfunction

   function automatic logic [DW-1:0] beat(int n);
      return {smp(3, n), smp(2, n), smp(1, n), smp(0, n)};
   endfunction

   function automatic logic [DW-1:0] w4(logic [W-1:0] s3, logic [W-1:0] s2, logic [W-1:0] s1, logic [W-1:0] s0);
      return {s3, s2, s1, s0};
   endfunction

   // Data is held when no word is emitted, and cleared by reset.
   task automatic add(logic rst, logic [N-1:0] en, logic we, logic [DW-1:0] data,
                      logic exp_en, logic [DW-1:0] exp_data, logic exp_sync);
      vec_t v;
      if (rst) hold = '0;
      else if (exp_en) hold = exp_data;
      v.rst = rst; v.en = en; v.we = we; v.data = data;
      v.exp_en = exp_en; v.exp_data = hold; v.exp_sync = exp_sync;
      vecs.push_back(v);
   endtask

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      hold   = '0;
      reset  = 1'b1;
      bus.enable = '0;
      bus.fifo_wr_en = 1'b0;
      bus.fifo_wr_data = '0;
      bus.packed_fifo_wr_overflow = 1'b0;

      // Reset state
      add(1, 4'hF, 0, '0, 0, '0, 0);
      // All channels: pass-through, sync on first word only
      add(0, 4'hF, 1, beat(0), 1, beat(0), 1);
      add(0, 4'hF, 1, beat(1), 1, beat(1), 0);
      add(0, 4'hF, 0, '0,      0, '0, 0);
      // Two channels: one word every two beats
      add(0, 4'h5, 0, '0,      0, '0, 0);
      add(0, 4'h5, 1, beat(0), 0, '0, 0);
      add(0, 4'h5, 1, beat(1), 1, w4(smp(2,1), smp(0,1), smp(2,0), smp(0,0)), 1);
      // Three channels: words straddle beats
      add(0, 4'h7, 1, beat(0), 0, '0, 0);
      add(0, 4'h7, 1, beat(1), 1, w4(smp(0,1), smp(2,0), smp(1,0), smp(0,0)), 1);
      add(0, 4'h7, 1, beat(2), 1, w4(smp(1,2), smp(0,2), smp(2,1), smp(1,1)), 0);
      add(0, 4'h7, 1, beat(3), 1, w4(smp(2,3), smp(1,3), smp(0,3), smp(2,2)), 0);
      add(0, 4'h7, 0, '0,      0, '0, 0);
      add(0, 4'h7, 1, beat(4), 0, '0, 0);
      add(0, 4'h7, 1, beat(5), 1, w4(smp(0,5), smp(2,4), smp(1,4), smp(0,4)), 0);
      // Enable change drops the partial word
      add(0, 4'h5, 1, beat(0), 0, '0, 0);
      add(0, 4'h1, 1, beat(1), 0, '0, 0);
      add(0, 4'h1, 1, beat(2), 0, '0, 0);
      add(0, 4'h1, 1, beat(3), 0, '0, 0);
      add(0, 4'h1, 1, beat(4), 1, w4(smp(0,4), smp(0,3), smp(0,2), smp(0,1)), 1);
      // No channels enabled: beats ignored
      add(0, 4'h0, 1, beat(5), 0, '0, 0);
      add(0, 4'h0, 1, beat(6), 0, '0, 0);
      add(0, 4'hF, 1, beat(7), 1, beat(7), 1);
      // Reset mid-word suppresses the completing emit
      add(0, 4'h5, 1, beat(5), 0, '0, 0);
      add(1, 4'h5, 1, beat(6), 0, '0, 0);
      add(0, 4'h5, 1, beat(7), 0, '0, 0);
      add(0, 4'h5, 1, beat(8), 1, w4(smp(2,8), smp(0,8), smp(2,7), smp(0,7)), 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset            = vecs[i].rst;
         bus.enable       = vecs[i].en;
         bus.fifo_wr_en   = vecs[i].we;
         bus.fifo_wr_data = vecs[i].data;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d en/sync/ovf/data", i),
               128'({bus.packed_fifo_wr_en, bus.packed_fifo_wr_sync, bus.fifo_wr_overflow, bus.packed_fifo_wr_data}),
               128'({vecs[i].exp_en, vecs[i].exp_sync, 1'b0, vecs[i].exp_data}));
      end

      // Overflow pulse of three cycles appears one clock later for three cycles
      begin
         logic ovf_pat [7];
         int   high_cnt;
         ovf_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         high_cnt = 0;
         for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            reset          = 1'b0;
            bus.fifo_wr_en = 1'b0;
            bus.packed_fifo_wr_overflow = ovf_pat[i];
            check($sformatf("ovf before edge %0d", i), 128'(bus.fifo_wr_overflow),
                  128'((i > 0) ? ovf_pat[i-1] : 1'b0));
            @(posedge clk);
            #1;
            check($sformatf("ovf after edge %0d", i), 128'(bus.fifo_wr_overflow), 128'(ovf_pat[i]));
            if (bus.fifo_wr_overflow) high_cnt++;
         end
         check("ovf high cycles", 128'(high_cnt), 128'(3));
         check("no emit during ovf", 128'(bus.packed_fifo_wr_en), 128'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
